// File: rtl/ccsds123_out_unpacker_pkg.sv
// Shared definitions for the compressed-output unpacker: serializer state
// encoding and a width helper used by the FIFO and the serializer.
package ccsds123_out_unpacker_pkg;

  // Serializer states: waiting for a word, or walking bytes out of the word register.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  // Width needed to index n items; never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ccsds123_word_fifo.sv
// Synchronous word FIFO with registered level. A push on a full FIFO is legal
// when a pop happens in the same cycle: the slot being read is the slot being
// written, and the read data is taken before the edge overwrites it.
module ccsds123_word_fifo
  import ccsds123_out_unpacker_pkg::*;
#(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       aresetn,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int AW = idx_width(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  // Guard against misuse: never write past full unless a pop frees the slot.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // Storage array.
  // NOTE: the memory has no reset on purpose; only pointers and level define
  // what is valid, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy count.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/ccsds123_out_unpacker.sv
// Receive side of the ccsds123_top compressed output. Buffers packed bitstream
// words (no backpressure toward the encoder) and re-emits them LSB byte first
// as an 8-bit AXI4-Stream. tlast travels with each word and is asserted on the
// final byte of a last-flagged word.
module ccsds123_out_unpacker
  import ccsds123_out_unpacker_pkg::*;
#(
  parameter int BUS_WIDTH  = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [BUS_WIDTH-1:0]          in_tdata,
  input  logic                          in_tvalid,
  input  logic                          in_tlast,
  output logic [7:0]                    out_tdata,
  output logic                          out_tvalid,
  input  logic                          out_tready,
  output logic                          out_tlast,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BUS_BYTES = BUS_WIDTH / 8;
  localparam int IDX_W     = idx_width(BUS_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUS_BYTES - 1);

  // FIFO interface
  logic                 w_fifo_push;
  logic                 w_fifo_pop;
  logic [BUS_WIDTH:0]   w_fifo_rd;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_drop;

  // Serializer state
  ser_state_t                 r_state;
  ser_state_t                 w_state_nxt;
  logic [BUS_BYTES-1:0][7:0]  r_word;
  logic                       r_word_last;
  logic [IDX_W-1:0]           r_idx;
  logic                       r_overflow;
  logic                       w_load;
  logic                       w_idx_inc;
  logic                       w_handshake;

  // A word is accepted if there is room, or if the serializer frees a slot
  // at this same edge; otherwise it is lost and the sticky flag records it.
  assign w_fifo_push = in_tvalid && (!w_fifo_full || w_fifo_pop);
  assign w_drop      = in_tvalid && w_fifo_full && !w_fifo_pop;

  ccsds123_word_fifo #(
    .WIDTH (BUS_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .aresetn (aresetn),
    .i_push  (w_fifo_push),
    .i_data  ({in_tlast, in_tdata}),
    .i_pop   (w_fifo_pop),
    .o_data  (w_fifo_rd),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (fifo_level)
  );

  assign w_handshake = out_tvalid && out_tready;

  // Serializer next-state logic: fetch a word, step the byte index on each
  // handshake, and chain straight into the next word with no idle cycle.
  // NOTE: every signal gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_fifo_pop  = 1'b0;
    w_load      = 1'b0;
    w_idx_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_fifo_pop  = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_handshake) begin
          if (r_idx != LAST_IDX) begin
            w_idx_inc = 1'b1;
          end else if (!w_fifo_empty) begin
            w_fifo_pop = 1'b1;
            w_load     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Serializer state register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Word register and byte index; cleared on reset so no stale byte survives.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_word      <= '0;
      r_word_last <= 1'b0;
      r_idx       <= '0;
    end else if (w_load) begin
      r_word      <= w_fifo_rd[BUS_WIDTH-1:0];
      r_word_last <= w_fifo_rd[BUS_WIDTH];
      r_idx       <= '0;
    end else if (w_idx_inc) begin
      r_idx <= r_idx + IDX_W'(1);
    end
  end

  // Sticky drop flag, cleared only by reset.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Outputs come straight from registers, so they hold while the sink stalls.
  assign out_tvalid = (r_state == ST_SHIFT);
  assign out_tdata  = r_word[r_idx];
  assign out_tlast  = (r_state == ST_SHIFT) && r_word_last && (r_idx == LAST_IDX);
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ccsds123_out_unpacker.sv
// Directed bench for the compressed-output unpacker: latency, byte order,
// tlast placement, stall stability, overflow, full push+pop and mid-word reset.
module tb_ccsds123_out_unpacker;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [63:0] in_tdata;
  logic        in_tvalid;
  logic        in_tlast;
  logic [7:0]  out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic        out_tlast;
  logic        overflow;
  logic [4:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  ccsds123_out_unpacker #(
    .BUS_WIDTH  (64),
    .FIFO_DEPTH (16)
  ) dut (
    .clk        (clk),
    .aresetn    (aresetn),
    .in_tdata   (in_tdata),
    .in_tvalid  (in_tvalid),
    .in_tlast   (in_tlast),
    .out_tdata  (out_tdata),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tlast  (out_tlast),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Word w (0-based) of the three-word image: byte j = {w+1, j}.
  function automatic logic [63:0] img_word(input int w);
    logic [63:0] v;
    for (int j = 0; j < 8; j++) v[j*8 +: 8] = 8'((w + 1) * 16 + j);
    return v;
  endfunction

  // Word i of the counting pattern: byte j = i*8+j.
  function automatic logic [63:0] cnt_word(input int i);
    logic [63:0] v;
    for (int j = 0; j < 8; j++) v[j*8 +: 8] = 8'(i * 8 + j);
    return v;
  endfunction

  task automatic push_word(input logic [63:0] d, input logic l);
    in_tdata  = d;
    in_tlast  = l;
    in_tvalid = 1'b1;
    tick();
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  // Consume n bytes. pattern 0: img_word sequence, 1: counting sequence.
  task automatic drain(input string tag, input int n, input bit rand_ready,
                       input bit pattern, input bit no_bubble);
    int         got = 0;
    int         cyc = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_d = '0;
    logic       prev_l = 1'b0;
    logic [7:0] exp_b;
    while (got < n && cyc < 2000) begin
      out_tready = rand_ready ? ($urandom_range(2, 0) == 0) : 1'b1;
      if (prev_stall) begin
        check({tag, "_hold_valid"}, 64'(out_tvalid), 64'd1);
        check({tag, "_hold_data"},  64'(out_tdata),  64'(prev_d));
        check({tag, "_hold_last"},  64'(out_tlast),  64'(prev_l));
      end
      if (no_bubble) check({tag, "_no_bubble"}, 64'(out_tvalid), 64'd1);
      if (out_tvalid && out_tready) begin
        exp_b = pattern ? 8'(got) : 8'((got / 8 + 1) * 16 + (got % 8));
        check({tag, "_byte"}, 64'(out_tdata), 64'(exp_b));
        check({tag, "_tlast"}, 64'(out_tlast), 64'(got == n - 1));
        got++;
      end
      prev_stall = out_tvalid && !out_tready;
      prev_d     = out_tdata;
      prev_l     = out_tlast;
      tick();
      cyc++;
    end
    check({tag, "_byte_count"}, 64'(got), 64'(n));
    out_tready = 1'b0;
  endtask

  // Absolute watchdog in case a wait is ever left unbounded.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn    = 1'b0;
    in_tdata   = '0;
    in_tvalid  = 1'b0;
    in_tlast   = 1'b0;
    out_tready = 1'b0;

    // Reset state
    #1;
    check("rst_valid",    64'(out_tvalid), 64'd0);
    check("rst_tlast",    64'(out_tlast),  64'd0);
    check("rst_tdata",    64'(out_tdata),  64'd0);
    check("rst_overflow", 64'(overflow),   64'd0);
    check("rst_level",    64'(fifo_level), 64'd0);
    tick();
    tick();
    aresetn = 1'b1;
    tick();

    // 1: single last word, 2-cycle latency, 8 consecutive bytes
    out_tready = 1'b1;
    push_word(64'h0807060504030201, 1'b1);
    check("t1_lat_valid0", 64'(out_tvalid), 64'd0);
    check("t1_lat_level1", 64'(fifo_level), 64'd1);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("t1_valid", 64'(out_tvalid), 64'd1);
      check("t1_byte",  64'(out_tdata),  64'(i + 1));
      check("t1_tlast", 64'(out_tlast),  64'(i == 7));
      tick();
    end
    check("t1_idle_valid", 64'(out_tvalid), 64'd0);
    check("t1_idle_level", 64'(fifo_level), 64'd0);

    // 2: three back-to-back words, continuous ready
    out_tready = 1'b0;
    for (int w = 0; w < 3; w++) push_word(img_word(w), w == 2);
    check("t2_level", 64'(fifo_level), 64'd2);
    drain("t2", 24, 1'b0, 1'b0, 1'b1);
    check("t2_idle_valid", 64'(out_tvalid), 64'd0);

    // 3: same image with a mostly-stalling sink
    for (int w = 0; w < 3; w++) push_word(img_word(w), w == 2);
    drain("t3", 24, 1'b1, 1'b0, 1'b0);
    tick();
    check("t3_idle_valid", 64'(out_tvalid), 64'd0);

    // 4: overflow with a stalled sink, then drain what was kept
    for (int i = 0; i < 18; i++) push_word(cnt_word(i), i >= 16);
    check("t4_overflow", 64'(overflow),   64'd1);
    check("t4_level",    64'(fifo_level), 64'd16);
    check("t4_valid",    64'(out_tvalid), 64'd1);
    check("t4_first",    64'(out_tdata),  64'h00);
    drain("t4", 136, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("t4_no_extra", 64'(out_tvalid), 64'd0);
      tick();
    end
    check("t4_overflow_sticky", 64'(overflow),   64'd1);
    check("t4_level_empty",     64'(fifo_level), 64'd0);

    // 6: reset in the middle of a word while a second word is buffered
    out_tready = 1'b1;
    push_word(64'h0807060504030201, 1'b1);
    push_word(64'h1817161514131211, 1'b1);
    tick();
    tick();
    tick();
    check("t6_pre_byte",  64'(out_tdata),  64'h04);
    check("t6_pre_level", 64'(fifo_level), 64'd1);
    aresetn = 1'b0;
    #1;
    check("t6_rst_valid",    64'(out_tvalid), 64'd0);
    check("t6_rst_overflow", 64'(overflow),   64'd0);
    check("t6_rst_level",    64'(fifo_level), 64'd0);
    check("t6_rst_tlast",    64'(out_tlast),  64'd0);
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t6_post_quiet", 64'(out_tvalid), 64'd0);
      tick();
    end
    push_word(64'hA8A7A6A5A4A3A2A1, 1'b1);
    tick();
    check("t6_new_valid", 64'(out_tvalid), 64'd1);
    check("t6_new_byte",  64'(out_tdata),  64'hA1);
    for (int i = 0; i < 8; i++) tick();
    check("t6_new_done", 64'(out_tvalid), 64'd0);

    // 5: push and pop in the same cycle on a full FIFO
    aresetn    = 1'b0;
    out_tready = 1'b0;
    #1;
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) push_word({8{8'(i)}}, 1'b0);
    check("t5_full_level",    64'(fifo_level), 64'd16);
    check("t5_full_overflow", 64'(overflow),   64'd0);
    out_tready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("t5_last_byte_w0", 64'(out_tdata),  64'h00);
    check("t5_level_before", 64'(fifo_level), 64'd16);
    in_tdata  = {8{8'h77}};
    in_tvalid = 1'b1;
    tick();
    in_tvalid = 1'b0;
    check("t5_overflow", 64'(overflow),   64'd0);
    check("t5_level",    64'(fifo_level), 64'd16);
    check("t5_valid",    64'(out_tvalid), 64'd1);
    check("t5_next_w1",  64'(out_tdata),  64'h01);
    out_tready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
